// File: rtl/inst_mem_loader_if.sv
// Byte stream in, instruction-side write port out, for inst_mem_loader.
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
// in_data is don't-care otherwise, and in_valid may stay high while in_ready is low.
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_write_width;
  logic [31:0]           mem_write_data;

  // master: the loader (sinks the byte stream, drives the memory write port)
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_write_enable, mem_addr, mem_write_width, mem_write_data
  );

  // slave: the byte source and the memory on the far side
  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_write_enable, mem_addr, mem_write_width, mem_write_data
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: little-endian word count + words from a byte stream into instruction memory.
// Optional trailing 8-bit checksum byte when INST_MEM_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader #(
  parameter int                    WORD_WIDTH_IN_BYTE = 4,
  parameter int                    ADDR_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE_ADDR     = '0,
  parameter int                    MAX_WORDS          = 524288
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  inst_mem_loader_if.master  bus,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t                state, state_next;
  logic [1:0]            byte_cnt;
  logic [31:0]           count;
  logic [31:0]           idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word_buf;
  logic                  ready;
  logic                  accept;
  logic [31:0]           hdr_count;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Full count as it will look once the 4th header byte lands this cycle.
  assign hdr_count = {bus.in_data, count[23:0]};
  assign accept    = bus.in_valid && ready;

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = HDR;
      HDR: begin
        ready = 1'b1;
        if (bus.in_valid && byte_cnt == 2'd3) begin
          if (hdr_count == 32'd0)                 state_next = DONE;
          else if (hdr_count > 32'(MAX_WORDS))    state_next = ERR;
          else                                    state_next = DATA;
        end
      end
      DATA: begin
        ready = 1'b1;
        if (bus.in_valid && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        if (idx + 32'd1 == count) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      CSUM: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = (bus.in_data == csum) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (start) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      count      <= 32'd0;
      idx        <= 32'd0;
      addr       <= LOAD_BASE_ADDR;
      word_buf   <= 32'd0;
      core_reset <= 1'b1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state      <= state_next;
      core_reset <= (state_next != DONE);
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            byte_cnt <= 2'd0;
            count    <= 32'd0;
            idx      <= 32'd0;
            addr     <= LOAD_BASE_ADDR;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        HDR: begin
          if (accept) begin
            count[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt                       <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (accept) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt                          <= byte_cnt + 2'd1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            csum                              <= csum + bus.in_data;
`endif
          end
        end
        WRITE: begin
          idx  <= idx + 32'd1;
          addr <= addr + ADDR_WIDTH'(4);
        end
        default: ;
      endcase
    end
  end

  // addr tracks LOAD_BASE_ADDR + 4*idx, so it is already correct in WRITE.
  assign bus.in_ready         = ready;
  assign bus.mem_write_enable = (state == WRITE);
  assign bus.mem_addr         = addr;
  assign bus.mem_write_width  = 4'd4;
  assign bus.mem_write_data   = word_buf;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  assign busy = (state == HDR) || (state == DATA) || (state == WRITE) || (state == CSUM);
`else
  assign busy = (state == HDR) || (state == DATA) || (state == WRITE);
`endif
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign fsm_state = state;

endmodule
